// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard scan-code FIFO: register selects and
// the STATUS register layout.
package kb_pkg;

   localparam int KB_REG_DATA   = 0;
   localparam int KB_REG_STATUS = 1;

   localparam int ST_NE      = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_PERR    = 3;
   localparam int ST_CNT_LSB = 4;

   // Field order matches the bit indices above, MSB first.
   typedef struct packed {
      logic [3:0] cnt;
      logic       perr;
      logic       ovf;
      logic       full;
      logic       ne;
   } kb_status_t;

endpackage

// File: rtl/kb_fifo_core.sv
// DEPTH x 8 scan-code buffer: write/read pointers, occupancy count and
// push/pop arbitration (a pop frees the slot for a same-cycle push).
module kb_fifo_core #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          not_empty,
   output logic          push_ok,
   output logic          pop_ok
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign full      = (count == FULL_CNT);
   assign not_empty = (count != '0);
   assign pop_ok    = pop & not_empty;
   assign push_ok   = push & (~full | pop_ok);
   assign head      = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/kb_scancode_fifo.sv
// Keyboard scan-code FIFO on the Z180 I/O window: bus-strobe synchroniser,
// end-of-read detect, sticky error flags, DATA/STATUS read mux and interrupt.
module kb_scancode_fifo
   import kb_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int AW          = 3,
   parameter int SYNC_STAGES = 2,
   parameter bit INT_EN      = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] CODE_IN,
   input  logic       CODE_VALID,
   input  logic       PARITY_ERR,
   input  logic       SEL_N,
   input  logic       A0,
   input  logic       RD_N,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   output logic       INT_N
);

   logic [SYNC_STAGES-1:0] acc_p;
   logic                   acc_dly;
   logic                   acc_s;
   logic                   acc;
   logic                   a0_lat;
   logic                   end_rd;
   logic                   pop_req;
   logic                   clr_req;
   logic                   ovf;
   logic                   perr;
   logic                   perr_evt;
   logic                   ovf_evt;
   logic [7:0]             head;
   logic [AW:0]            count;
   logic                   full;
   logic                   not_empty;
   logic                   push_ok;
   logic                   pop_ok;
   kb_status_t             status;

   function automatic kb_status_t pack_status(input logic [AW:0] cnt,
                                              input logic p_err,
                                              input logic o_flow,
                                              input logic is_full,
                                              input logic is_ne);
      kb_status_t s;
      logic [7:0] c8;
      c8     = 8'(cnt);
      s.cnt  = c8[3:0];
      s.perr = p_err;
      s.ovf  = o_flow;
      s.full = is_full;
      s.ne   = is_ne;
      return s;
   endfunction

   assign acc  = ~SEL_N & ~RD_N;
   assign D_OE = acc;

   // Synchroniser; the delayed copy of the last stage gives the falling edge.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         acc_p   <= '0;
         acc_dly <= 1'b0;
         a0_lat  <= 1'b0;
      end else begin
         acc_p   <= {acc_p[SYNC_STAGES-2:0], acc};
         acc_dly <= acc_p[SYNC_STAGES-1];
         if (acc_p[SYNC_STAGES-1]) a0_lat <= A0;
      end
   end

   assign acc_s   = acc_p[SYNC_STAGES-1];
   assign end_rd  = acc_dly & ~acc_s;
   assign pop_req = end_rd & (a0_lat == 1'(KB_REG_DATA));
   assign clr_req = end_rd & (a0_lat == 1'(KB_REG_STATUS));

   kb_fifo_core #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_core (
      .CLK       (CLK),
      .RST       (RST),
      .push      (CODE_VALID & ~PARITY_ERR),
      .pop       (pop_req),
      .din       (CODE_IN),
      .head      (head),
      .count     (count),
      .full      (full),
      .not_empty (not_empty),
      .push_ok   (push_ok),
      .pop_ok    (pop_ok)
   );

   assign perr_evt = CODE_VALID & PARITY_ERR;
   assign ovf_evt  = CODE_VALID & ~PARITY_ERR & ~push_ok;

   // A new error event in the clearing cycle keeps its flag set.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         perr  <= 1'b0;
         ovf   <= 1'b0;
         INT_N <= 1'b1;
      end else begin
         if (perr_evt)     perr <= 1'b1;
         else if (clr_req) perr <= 1'b0;
         if (ovf_evt)      ovf  <= 1'b1;
         else if (clr_req) ovf  <= 1'b0;
         INT_N <= ~(INT_EN & not_empty);
      end
   end

   assign status = pack_status(count, perr, ovf, full, not_empty);

   always_comb begin
      D_OUT = 8'h00;
      if (A0 == 1'(KB_REG_STATUS)) D_OUT = status;
      else if (not_empty)          D_OUT = head;
   end

endmodule

// File: tb/tb_kb_scancode_fifo.sv
// Self-checking bench for kb_scancode_fifo (DEPTH=8) with a queue scoreboard
// and a small count/flag model.
module tb_kb_scancode_fifo;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] CODE_IN = 8'h00;
   logic       CODE_VALID = 1'b0;
   logic       PARITY_ERR = 1'b0;
   logic       SEL_N = 1'b1;
   logic       A0 = 1'b0;
   logic       RD_N = 1'b1;
   logic [7:0] D_OUT;
   logic       D_OE;
   logic       INT_N;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] sb[$];
   int         m_cnt  = 0;
   bit         m_ovf  = 1'b0;
   bit         m_perr = 1'b0;
   logic [7:0] d;
   logic       i3, i4;

   kb_scancode_fifo #(
      .DEPTH       (8),
      .AW          (3),
      .SYNC_STAGES (2),
      .INT_EN      (1'b1)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CODE_IN    (CODE_IN),
      .CODE_VALID (CODE_VALID),
      .PARITY_ERR (PARITY_ERR),
      .SEL_N      (SEL_N),
      .A0         (A0),
      .RD_N       (RD_N),
      .D_OUT      (D_OUT),
      .D_OE       (D_OE),
      .INT_N      (INT_N)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] exp_status();
      return {4'(m_cnt), m_perr, m_ovf, (m_cnt == 8), (m_cnt != 0)};
   endfunction

   task automatic push_code(input logic [7:0] code, input bit perr);
      @(negedge CLK);
      CODE_IN    = code;
      CODE_VALID = 1'b1;
      PARITY_ERR = perr;
      if (perr) m_perr = 1'b1;
      else if (m_cnt < 8) begin
         sb.push_back(code);
         m_cnt++;
      end else m_ovf = 1'b1;
      @(negedge CLK);
      CODE_VALID = 1'b0;
      PARITY_ERR = 1'b0;
   endtask

   // One bus read; optionally drives CODE_VALID in the end_rd cycle.
   task automatic bus_read(input string tag, input bit a0, input bit do_push,
                           input logic [7:0] code, output logic [7:0] rd,
                           output logic int3, output logic int4);
      logic [7:0] exp_d;
      bit         popd;
      exp_d = a0 ? exp_status() : ((sb.size() != 0) ? sb[0] : 8'h00);
      @(negedge CLK);
      SEL_N = 1'b0;
      A0    = a0;
      RD_N  = 1'b0;
      repeat (3) @(negedge CLK);
      rd = D_OUT;
      chk({tag, "_d_oe"}, 16'(D_OE), 16'h1);
      chk(tag, 16'(rd), 16'(exp_d));
      RD_N  = 1'b1;
      SEL_N = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      if (do_push) begin
         CODE_IN    = code;
         CODE_VALID = 1'b1;
      end
      @(negedge CLK);
      CODE_VALID = 1'b0;
      int3 = INT_N;
      @(negedge CLK);
      int4 = INT_N;
      repeat (2) @(negedge CLK);
      popd = (a0 == 1'b0) && (m_cnt > 0);
      if (a0) begin
         m_ovf  = 1'b0;
         m_perr = 1'b0;
      end
      if (popd) begin
         void'(sb.pop_front());
         m_cnt--;
      end
      if (do_push) begin
         if (m_cnt < 8) begin
            sb.push_back(code);
            m_cnt++;
         end else m_ovf = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge CLK);
      A0 = 1'b1;
      @(negedge CLK);
      chk("rst_status", 16'(D_OUT), 16'h00);
      chk("rst_int_n", 16'(INT_N), 16'h1);
      chk("rst_d_oe", 16'(D_OE), 16'h0);
      RST = 1'b1;
      A0  = 1'b0;
      @(negedge CLK);
      chk("rst_head", 16'(D_OUT), 16'h00);

      // 1: single code, interrupt timing
      push_code(8'h1C, 1'b0);
      chk("t1_int_pre", 16'(INT_N), 16'h1);
      @(negedge CLK);
      chk("t1_int_asserted", 16'(INT_N), 16'h0);
      bus_read("t1_status_pre", 1'b1, 1'b0, 8'h00, d, i3, i4);
      bus_read("t1_data", 1'b0, 1'b0, 8'h00, d, i3, i4);
      chk("t1_int_3clk", 16'(i3), 16'h0);
      chk("t1_int_4clk", 16'(i4), 16'h1);
      bus_read("t1_status_post", 1'b1, 1'b0, 8'h00, d, i3, i4);

      // 2: overflow
      for (int i = 1; i <= 9; i++) push_code(8'(i), 1'b0);
      bus_read("t2_status_ovf", 1'b1, 1'b0, 8'h00, d, i3, i4);
      chk("t2_status_const", 16'(d), 16'h87);
      for (int i = 1; i <= 9; i++) bus_read($sformatf("t2_data%0d", i), 1'b0, 1'b0, 8'h00, d, i3, i4);
      chk("t2_ninth_zero", 16'(d), 16'h00);
      chk("t2_int_idle", 16'(INT_N), 16'h1);

      // 3: parity error, status clear
      push_code(8'h55, 1'b1);
      bus_read("t3_status_perr", 1'b1, 1'b0, 8'h00, d, i3, i4);
      chk("t3_status_const", 16'(d), 16'h08);
      bus_read("t3_status_clr", 1'b1, 1'b0, 8'h00, d, i3, i4);

      // 4: push in the pop cycle while full
      for (int i = 0; i < 8; i++) push_code(8'hA0 + 8'(i), 1'b0);
      bus_read("t4_data_pop_push", 1'b0, 1'b1, 8'hB0, d, i3, i4);
      bus_read("t4_status", 1'b1, 1'b0, 8'h00, d, i3, i4);
      chk("t4_status_const", 16'(d), 16'h83);
      for (int i = 0; i < 8; i++) bus_read($sformatf("t4_drain%0d", i), 1'b0, 1'b0, 8'h00, d, i3, i4);

      // 5: pointer wrap
      for (int i = 0; i < 20; i++) begin
         push_code(8'h30 + 8'(i), 1'b0);
         bus_read($sformatf("t5_wrap%0d", i), 1'b0, 1'b0, 8'h00, d, i3, i4);
      end
      bus_read("t5_status", 1'b1, 1'b0, 8'h00, d, i3, i4);

      // 6: reset during an active DATA access
      for (int i = 0; i < 3; i++) push_code(8'h60 + 8'(i), 1'b0);
      @(negedge CLK);
      SEL_N = 1'b0;
      A0    = 1'b0;
      RD_N  = 1'b0;
      repeat (3) @(negedge CLK);
      chk("t6_head_pre", 16'(D_OUT), 16'h60);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      sb.delete();
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      @(negedge CLK);
      chk("t6_head_empty", 16'(D_OUT), 16'h00);
      chk("t6_int_n", 16'(INT_N), 16'h1);
      repeat (3) @(negedge CLK);
      RD_N  = 1'b1;
      SEL_N = 1'b1;
      repeat (6) @(negedge CLK);
      bus_read("t6_status", 1'b1, 1'b0, 8'h00, d, i3, i4);
      chk("t6_int_after", 16'(INT_N), 16'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
